// File: rtl/block_transfer_sequencer.sv
// block_transfer_sequencer
//
// Purpose:
//   Initiator-side register sequencer for ARM1 block data transfers (LDM/STM).
//   It latches a 16-bit register list and walks it lowest register first. For
//   each accepted beat it presents one register number to the register bank.
//   It also drives the matching bus-B read enable (store) or write enable
//   (load), and the user-bank force_mode qualifier. The transfer count and the
//   PC-in-list flag are reported for base offset and writeback logic.
//
// Ports:
//   phi1_clock  in   single clock, rising-edge
//   reset       in   synchronous, active-high
//   start       in   transfer request, sampled only while idle
//   reg_list    in   register list, bit n = rn (sampled with start)
//   load        in   1 = LDM, 0 = STM (sampled with start)
//   force_user  in   S bit, user-bank access (sampled with start)
//   mem_ready   in   memory side accepts the current beat this cycle
//   busy        out  high while a transfer is in progress (COUNT/XFER/DONE)
//   reg_nb      out  register number of the current beat
//   reg_valid   out  a beat is being presented
//   read_b_en   out  bank read on bus B (store beats)
//   write_en    out  bank write (load beats)
//   force_mode  out  user-bank qualifier while busy
//   first       out  current beat is the first of the transfer
//   last        out  current beat is the final one
//   xfer_count  out  number of registers in the latched list (0..16)
//   pc_in_list  out  r15 is part of the latched list
//   done        out  one-cycle completion pulse
module block_transfer_sequencer #(
  parameter int LIST_W = 16
) (
  input  logic              phi1_clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LIST_W-1:0] reg_list,
  input  logic              load,
  input  logic              force_user,
  input  logic              mem_ready,
  output logic              busy,
  output logic [3:0]        reg_nb,
  output logic              reg_valid,
  output logic              read_b_en,
  output logic              write_en,
  output logic              force_mode,
  output logic              first,
  output logic              last,
  output logic [4:0]        xfer_count,
  output logic              pc_in_list,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_XFER,
    ST_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [LIST_W-1:0] pending;
  logic              load_q;
  logic              force_user_q;
  logic              first_q;

  logic [3:0]        lowest_nb;
  logic [LIST_W-1:0] lowest_onehot;
  logic [4:0]        pending_count;
  logic              single_bit;
  logic              beat_accept;

  // Priority encoder, lowest set bit wins. Scanning from the top down lets
  // the lowest index overwrite any higher one.
  always_comb begin
    lowest_nb = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (pending[i]) lowest_nb = 4'(i);
    end
  end

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < LIST_W; i++) begin
      pending_count = pending_count + 5'(pending[i]);
    end
  end

  // x & -x isolates the lowest set bit. x & (x-1) is zero only when at most
  // one bit is set.
  assign lowest_onehot = pending & (~pending + {{(LIST_W-1){1'b0}}, 1'b1});
  assign single_bit    = (pending != '0) &&
                         ((pending & (pending - {{(LIST_W-1){1'b0}}, 1'b1})) == '0);
  assign beat_accept   = (state_q == ST_XFER) && mem_ready;

  always_ff @(posedge phi1_clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers. xfer_count and pc_in_list are captured at COUNT exit
  // and then hold until the next accepted start.
  always_ff @(posedge phi1_clock) begin
    if (reset) begin
      pending      <= '0;
      load_q       <= 1'b0;
      force_user_q <= 1'b0;
      first_q      <= 1'b0;
      xfer_count   <= '0;
      pc_in_list   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        pending      <= reg_list;
        load_q       <= load;
        force_user_q <= force_user;
      end
      if (state_q == ST_COUNT) begin
        xfer_count <= pending_count;
        pc_in_list <= pending[LIST_W-1];
        first_q    <= 1'b1;
      end
      if (beat_accept) begin
        pending <= pending & ~lowest_onehot;
        first_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    reg_valid  = 1'b0;
    reg_nb     = '0;
    first      = 1'b0;
    last       = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        busy    = 1'b1;
        state_d = (pending == '0) ? ST_DONE : ST_XFER;
      end
      ST_XFER: begin
        busy      = 1'b1;
        reg_valid = 1'b1;
        reg_nb    = lowest_nb;
        first     = first_q;
        last      = single_bit;
        if (mem_ready && single_bit) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign read_b_en  = reg_valid & ~load_q;
  assign write_en   = reg_valid & load_q;
  assign force_mode = force_user_q & busy;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// tb_block_transfer_sequencer
//
// Purpose:
//   Self-checking bench for block_transfer_sequencer. Each transfer request
//   queues the beats it should produce. A monitor compares every presented
//   beat against the head of the queue and retires the entry when memory
//   accepts it. Per-transfer checks cover done latency, the transfer count,
//   the PC flag and the post-transfer idle state.
//
// Ports: none (top-level bench).
module tb_block_transfer_sequencer;

  logic        phi1_clock;
  logic        reset;
  logic        start;
  logic [15:0] reg_list;
  logic        load;
  logic        force_user;
  logic        mem_ready;
  logic        busy;
  logic [3:0]  reg_nb;
  logic        reg_valid;
  logic        read_b_en;
  logic        write_en;
  logic        force_mode;
  logic        first;
  logic        last;
  logic [4:0]  xfer_count;
  logic        pc_in_list;
  logic        done;

  typedef struct {
    logic [3:0] nb;
    logic       ld;
    logic       fst;
    logic       lst;
    logic       fm;
  } beat_t;

  beat_t sb_q[$];
  int    checks       = 0;
  int    errors       = 0;
  int    valid_cycles = 0;
  int    stall_reg    = -1;
  int    stall_left   = 0;

  block_transfer_sequencer #(.LIST_W(16)) dut (
    .phi1_clock (phi1_clock),
    .reset      (reset),
    .start      (start),
    .reg_list   (reg_list),
    .load       (load),
    .force_user (force_user),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .reg_nb     (reg_nb),
    .reg_valid  (reg_valid),
    .read_b_en  (read_b_en),
    .write_en   (write_en),
    .force_mode (force_mode),
    .first      (first),
    .last       (last),
    .xfer_count (xfer_count),
    .pc_in_list (pc_in_list),
    .done       (done)
  );

  initial phi1_clock = 1'b0;
  always #5 phi1_clock = ~phi1_clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Memory-side model: accepts every beat except when told to stall on a
  // particular register for a number of cycles.
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge phi1_clock);
      #1;
      if (reg_valid === 1'b1 && stall_left > 0 && int'(reg_nb) == stall_reg) begin
        mem_ready  = 1'b0;
        stall_left = stall_left - 1;
      end else begin
        mem_ready = 1'b1;
      end
    end
  end

  // Beat monitor, sampled mid-cycle on the falling edge.
  always @(negedge phi1_clock) begin
    if (reg_valid === 1'b1) begin
      valid_cycles++;
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_beat", 32'd1, 32'd0);
      end else begin
        checkOutput("reg_nb",     32'(reg_nb),     32'(sb_q[0].nb));
        checkOutput("read_b_en",  32'(read_b_en),  32'(!sb_q[0].ld));
        checkOutput("write_en",   32'(write_en),   32'(sb_q[0].ld));
        checkOutput("first",      32'(first),      32'(sb_q[0].fst));
        checkOutput("last",       32'(last),       32'(sb_q[0].lst));
        checkOutput("force_mode", 32'(force_mode), 32'(sb_q[0].fm));
        checkOutput("busy_xfer",  32'(busy),       32'd1);
        if (mem_ready) void'(sb_q.pop_front());
      end
    end
  end

  // One full transfer. Optionally stalls memory on a chosen register, and
  // optionally re-asserts start with a different list at a given cycle.
  task automatic applyStimulus(input logic [15:0] list, input logic ld,
                               input logic fu, input int st_reg, input int st_n,
                               input int restart_at, input logic [15:0] alt_list);
    beat_t       b;
    int          n;
    int          k;
    int          cycles;
    int          exp_latency;
    logic [15:0] lst_v;

    lst_v = list;
    n     = $countones(lst_v);
    k     = 0;
    @(posedge phi1_clock);
    #1;
    start        = 1'b1;
    reg_list     = lst_v;
    load         = ld;
    force_user   = fu;
    stall_reg    = st_reg;
    stall_left   = st_n;
    valid_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst_v[i]) begin
        b.nb  = 4'(i);
        b.ld  = ld;
        b.fst = (k == 0);
        b.lst = (k == n - 1);
        b.fm  = fu;
        sb_q.push_back(b);
        k++;
      end
    end
    exp_latency = (n == 0) ? 2 : n + 2 + st_n;

    cycles = 0;
    do begin
      @(posedge phi1_clock);
      #1;
      cycles++;
      start = (cycles == restart_at);
      if (cycles == restart_at) begin
        reg_list = alt_list;
        load     = ~ld;
      end
      if (cycles == 2) checkOutput("count_early", 32'(xfer_count), 32'(n));
    end while (done !== 1'b1 && cycles < 80);
    start = 1'b0;

    checkOutput("done_latency", 32'(cycles),       32'(exp_latency));
    checkOutput("xfer_count",   32'(xfer_count),   32'(n));
    checkOutput("pc_in_list",   32'(pc_in_list),   32'(lst_v[15]));
    checkOutput("busy_done",    32'(busy),         32'd1);
    checkOutput("valid_done",   32'(reg_valid),    32'd0);
    checkOutput("force_done",   32'(force_mode),   32'(fu));
    checkOutput("valid_cycles", 32'(valid_cycles), 32'(n + st_n));
    checkOutput("beats_left",   32'(sb_q.size()),  32'd0);

    @(posedge phi1_clock);
    #1;
    checkOutput("done_pulse",   32'(done),       32'd0);
    checkOutput("busy_idle",    32'(busy),       32'd0);
    checkOutput("force_idle",   32'(force_mode), 32'd0);
    checkOutput("count_hold",   32'(xfer_count), 32'(n));
    checkOutput("pc_hold",      32'(pc_in_list), 32'(lst_v[15]));
    sb_q.delete();
  endtask

  // Abandons a transfer of 16'h00FF by asserting reset on its third beat.
  task automatic applyResetMidXfer();
    beat_t b;
    int    cycles;
    logic  hit;

    @(posedge phi1_clock);
    #1;
    start        = 1'b1;
    reg_list     = 16'h00FF;
    load         = 1'b0;
    force_user   = 1'b1;
    stall_reg    = -1;
    stall_left   = 0;
    for (int i = 0; i < 8; i++) begin
      b.nb  = 4'(i);
      b.ld  = 1'b0;
      b.fst = (i == 0);
      b.lst = (i == 7);
      b.fm  = 1'b1;
      sb_q.push_back(b);
    end

    cycles = 0;
    hit    = 1'b0;
    do begin
      @(posedge phi1_clock);
      #1;
      start = 1'b0;
      cycles++;
      if (reg_valid === 1'b1 && reg_nb == 4'd2) begin
        reset = 1'b1;
        hit   = 1'b1;
      end
    end while (!hit && cycles < 20);
    checkOutput("third_beat_seen", 32'(hit), 32'd1);

    @(posedge phi1_clock);
    #1;
    reset = 1'b0;
    sb_q.delete();
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_valid",      32'(reg_valid),  32'd0);
    checkOutput("rst_reg_nb",     32'(reg_nb),     32'd0);
    checkOutput("rst_read_b_en",  32'(read_b_en),  32'd0);
    checkOutput("rst_force_mode", 32'(force_mode), 32'd0);
    checkOutput("rst_first_last", 32'({first, last}), 32'd0);
    checkOutput("rst_xfer_count", 32'(xfer_count), 32'd0);
    checkOutput("rst_pc_in_list", 32'(pc_in_list), 32'd0);
    checkOutput("rst_done",       32'(done),       32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge phi1_clock);
      #1;
      checkOutput("no_valid_after_reset", 32'(reg_valid), 32'd0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    reg_list   = '0;
    load       = 1'b0;
    force_user = 1'b0;
    repeat (2) @(posedge phi1_clock);
    #1;
    checkOutput("reset_busy",       32'(busy),       32'd0);
    checkOutput("reset_valid",      32'(reg_valid),  32'd0);
    checkOutput("reset_reg_nb",     32'(reg_nb),     32'd0);
    checkOutput("reset_xfer_count", 32'(xfer_count), 32'd0);
    checkOutput("reset_done",       32'(done),       32'd0);
    checkOutput("reset_enables",    32'({read_b_en, write_en, force_mode}), 32'd0);
    reset = 1'b0;

    $display("[TB] STM 8005");
    applyStimulus(16'h8005, 1'b0, 1'b0, -1, 0, -1, 16'h0000);
    $display("[TB] LDM 0010 with S bit");
    applyStimulus(16'h0010, 1'b1, 1'b1, -1, 0, -1, 16'h0000);
    $display("[TB] empty list");
    applyStimulus(16'h0000, 1'b0, 1'b0, -1, 0, -1, 16'h0000);
    $display("[TB] LDM FFFF with stall on r7");
    applyStimulus(16'hFFFF, 1'b1, 1'b0, 7, 3, -1, 16'h0000);
    $display("[TB] start re-asserted mid-transfer");
    applyStimulus(16'h0A50, 1'b0, 1'b0, -1, 0, 3, 16'h0003);
    $display("[TB] reset on third beat");
    applyResetMidXfer();
    applyStimulus(16'h0002, 1'b1, 1'b0, -1, 0, -1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
